// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the 18-bit receiver.
package uart_pkg;
  localparam int UART_WIDTH         = 18;
  localparam int DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous word FIFO feeding the UART shifter; power-of-two depth, pointers wrap naturally.
module uart_tx_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr,
  input  logic                         rd,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_next;
  logic             do_wr, do_rd;

  // Space is judged on the count before the edge, so a same-edge pop never frees room.
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;
  assign head  = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_wr && !do_rd)
      count_next = count + 1'b1;
    else if (!do_wr && do_rd)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/uart_tx.sv
// 18-bit UART transmitter: start bit, 18 data bits LSB first, stop bit, OVERSAMPLE clocks per bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                  rxclk,
  input  logic                  reset_n,
  input  logic [UART_WIDTH-1:0] tx_data,
  input  logic                  ld_tx_data,
  input  logic                  tx_enable,
  output logic                  tx_out,
  output logic                  tx_busy,
  output logic                  tx_empty,
  output logic                  tx_full,
  output logic                  tx_overflow
);
  localparam int PW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(UART_WIDTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  tx_state_t             state, state_n;
  logic [PW-1:0]         phase, phase_n;
  logic [IW-1:0]         idx, idx_n;
  logic [UART_WIDTH-1:0] shift, shift_n;
  logic                  tx_out_n;
  logic                  pop, last, can_start;
  logic [UART_WIDTH-1:0] fifo_head;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;

  uart_tx_fifo #(
    .WIDTH (UART_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (rxclk),
    .reset_n (reset_n),
    .wr      (ld_tx_data),
    .rd      (pop),
    .din     (tx_data),
    .head    (fifo_head),
    .count   (fifo_count),
    .full    (tx_full),
    .empty   (fifo_empty)
  );

  assign last      = (phase == PW'(OVERSAMPLE - 1));
  assign can_start = !fifo_empty && tx_enable;
  assign tx_busy   = (state != IDLE);
  assign tx_empty  = fifo_empty && (state == IDLE);

  always_comb begin
    state_n  = state;
    phase_n  = phase + 1'b1;
    idx_n    = idx;
    shift_n  = shift;
    tx_out_n = tx_out;
    pop      = 1'b0;
    if (last) phase_n = '0;
    case (state)
      IDLE: begin
        phase_n  = '0;
        tx_out_n = 1'b1;
        if (can_start) begin
          pop      = 1'b1;
          shift_n  = fifo_head;
          tx_out_n = 1'b0;
          state_n  = START;
        end
      end
      START: begin
        if (last) begin
          tx_out_n = shift[0];
          idx_n    = '0;
          state_n  = DATA;
        end
      end
      DATA: begin
        if (last) begin
          shift_n = shift >> 1;
          if (idx == IW'(UART_WIDTH - 1)) begin
            tx_out_n = 1'b1;
            state_n  = STOP;
          end else begin
            tx_out_n = shift[1];
            idx_n    = idx + 1'b1;
          end
        end
      end
      STOP: begin
        // Chaining straight from the stop bit keeps streamed frames gap-free.
        if (last) begin
          tx_out_n = 1'b1;
          state_n  = IDLE;
          if (can_start) begin
            pop      = 1'b1;
            shift_n  = fifo_head;
            tx_out_n = 1'b0;
            state_n  = START;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      phase       <= '0;
      idx         <= '0;
      tx_out      <= 1'b1;
      tx_overflow <= 1'b0;
    end else begin
      state  <= state_n;
      phase  <= phase_n;
      idx    <= idx_n;
      tx_out <= tx_out_n;
      if (ld_tx_data && (fifo_count == CW'(FIFO_DEPTH)))
        tx_overflow <= 1'b1;
    end
  end

  always_ff @(posedge rxclk) begin
    shift <= shift_n;
  end
endmodule
